mux_arb_nt1: RTL and testbench
==============================

Name: mux_arb_nt1

Overview:
Parametrised N-to-1 data multiplexer, the registered successor of the 2:1 64-bit select mux.
- Two selection modes: fixed select (external sel) and round-robin arbitration across NCH request channels.
- valid/ready handshake on every input channel and on the output.
- One-entry registered output stage.
- Sits between multiple producers (e.g. adder/ALU result channels) and a single consumer.

Parameters:
WIDTH, 64, data bits per channel
SELW, 2, select/channel-index width; NCH = 2**SELW channels (localparam, default 4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
in_data  input  NCH*WIDTH  packed inputs; channel k at [k*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready (combinational)
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  index of the channel that produced out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready is forced to all-zero while rst_n=0.
- Accept condition: can_acc = !out_valid | out_ready.
- Channel transfer: on channel k when in_valid[k] & in_ready[k] at the clock edge.
- Output transfer: when out_valid & out_ready.
- Fixed mode (mode=0):
  - grant = sel.
  - in_ready[sel] = can_acc; all other in_ready bits are 0.
  - in_valid[sel] is required for a transfer.
- Round-robin mode (mode=1):
  - grant = first k with in_valid[k]=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (wrap mod NCH).
  - in_ready[grant] = can_acc; all other bits 0.
  - No valid input: in_ready = 0 and no transfer.
- ptr update: on every accepted transfer in round-robin mode, ptr <= grant+1 mod NCH (NCH-1 wraps to 0). ptr is unchanged in fixed mode and on idle cycles.
- On transfer: out_data <= granted in_data slice, out_ch <= grant, out_valid <= 1.
- Latency: exactly 1 cycle from channel transfer to out_valid. Full throughput of one word per cycle while out_ready=1.
- Output drain without new transfer: out_valid <= 0. out_data and out_ch hold their last values.
- Backpressure (out_valid=1, out_ready=0): out_data, out_ch, out_valid hold; all in_ready = 0.
- Simultaneous drain and accept in the same cycle: the new word replaces the old one, out_valid stays 1, no bubble.
- mode/sel changes: arbitration is combinational, so a change affects only the grant in the same cycle. A word already in the output register is unaffected.
- Out-of-range sel cannot occur (NCH = 2**SELW).
- Reset mid-operation: the held word is discarded, out_valid drops immediately, ptr returns to 0.

Optional Feature:
MUX_PKT_LOCK_EN
- With macro: adds ports in_last (input, NCH) and out_last (output, 1, registered alongside out_data, reset 0).
  - In round-robin mode, once channel g transfers a word with in_last[g]=0, the grant is locked to g until g transfers a word with in_last[g]=1.
  - ptr advances to g+1 only on that last transfer.
  - While locked, other channels' in_ready = 0 even if g is not valid.
  - Fixed mode ignores the lock but still passes out_last.
  - A lock is cleared by reset or by switching mode to 0.
- Without macro: no in_last/out_last ports; the grant is recomputed every cycle as above.

Test Plan:
- Reset and idle: rst_n low mid-transfer -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately. After release with no valid inputs, out_valid stays 0.
- Fixed select: mode=0, sel=2, all in_valid=1, in_data ch2=64'hDEADBEEF_00000002, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=64'hDEADBEEF_00000002, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1010 -> out_ch 1,3,1,3.
- Backpressure: word from ch1 held, out_ready=0 for 3 cycles -> out_data/out_ch stable, in_ready=0. out_ready=1 with ch3 valid -> ch3 word loads the same cycle the ch1 word drains, out_valid stays 1.
- Wrap and skip: ptr=3, in_valid=4'b0001 -> grant 0, ptr becomes 1. Then in_valid=4'b0001 again -> grant 0 (searched 1,2,3 first).
- With MUX_PKT_LOCK_EN: ch1 sends 3 words with last on the 3rd while ch0 and ch2 are valid -> out_ch 1,1,1, then 2. in_ready[0] and in_ready[2] stay 0 during the lock.

Source files
------------

// File: rtl/mux_arb_nt1.sv
// N-to-1 valid/ready mux with fixed-select and round-robin modes and a one-entry output register.
// Define MUX_PKT_LOCK_EN to add in_last/out_last and hold the round-robin grant for a whole packet.
module mux_arb_nt1 #(
  parameter int WIDTH = 64,
  parameter int SELW  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic [SELW-1:0]               sel,
  input  logic [(2**SELW)*WIDTH-1:0]    in_data,
  input  logic [(2**SELW)-1:0]          in_valid,
  output logic [(2**SELW)-1:0]          in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [(2**SELW)-1:0]          in_last,
  output logic                          out_last,
`endif
  output logic [WIDTH-1:0]              out_data,
  output logic [SELW-1:0]               out_ch,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int NCH = 2**SELW;

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_grant;
  logic            rr_hit;
  logic [SELW-1:0] idx;
  logic [SELW-1:0] grant;
  logic            have_grant;
  logic            can_acc;
  logic            xfer;

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {FREE, LOCKED} lock_e;
  lock_e           lock_state;
  logic [SELW-1:0] lock_ch;
`endif

  assign can_acc = !out_valid || out_ready;

  // Search starts at ptr; the SELW-bit sum wraps modulo NCH on its own.
  always_comb begin
    rr_grant = ptr;
    rr_hit   = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = ptr + SELW'(i);
      if (!rr_hit && in_valid[idx]) begin
        rr_grant = idx;
        rr_hit   = 1'b1;
      end
    end
  end

  always_comb begin
    grant      = sel;
    have_grant = 1'b1;
    if (mode) begin
`ifdef MUX_PKT_LOCK_EN
      if (lock_state == LOCKED) begin
        grant      = lock_ch;
        have_grant = 1'b1;
      end else begin
        grant      = rr_grant;
        have_grant = rr_hit;
      end
`else
      grant      = rr_grant;
      have_grant = rr_hit;
`endif
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && have_grant && can_acc)
      in_ready[grant] = 1'b1;
  end

  assign xfer = in_valid[grant] && in_ready[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
      ptr        <= '0;
`ifdef MUX_PKT_LOCK_EN
      out_last   <= 1'b0;
      lock_state <= FREE;
      lock_ch    <= '0;
`endif
    end else begin
      if (xfer) begin
        out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_ch    <= grant;
        out_valid <= 1'b1;
`ifdef MUX_PKT_LOCK_EN
        out_last  <= in_last[grant];
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

`ifdef MUX_PKT_LOCK_EN
      // The pointer moves past a channel only when its packet ends.
      if (!mode) begin
        lock_state <= FREE;
      end else if (xfer) begin
        if (in_last[grant]) begin
          lock_state <= FREE;
          ptr        <= grant + SELW'(1);
        end else begin
          lock_state <= LOCKED;
          lock_ch    <= grant;
        end
      end
`else
      if (mode && xfer)
        ptr <= grant + SELW'(1);
`endif
    end
  end

endmodule

// File: tb/tb_mux_arb_nt1.sv
// Directed scoreboard bench for mux_arb_nt1: stimulus pushes expected words, a negedge monitor pops them.
// Lock-mode vectors run only when MUX_PKT_LOCK_EN is defined.
module tb_mux_arb_nt1;
  localparam int WIDTH = 64;
  localparam int SELW  = 2;
  localparam int NCH   = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   in_data;
  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [NCH-1:0]         in_last;
  logic [WIDTH-1:0]       out_data;
  logic [SELW-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;
`ifdef MUX_PKT_LOCK_EN
  logic                   out_last;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_arb_nt1 #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [31:0] tag, input int k);
    return {tag, 32'(k)};
  endfunction

  task automatic drive(input logic m, input logic [SELW-1:0] s, input logic [NCH-1:0] v,
                       input logic ordy, input logic [31:0] tag, input int exp_ch,
                       input logic [NCH-1:0] last, input logic exp_last);
    exp_t e;
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    in_last   = last;
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = mk(tag, k);
    if (exp_ch >= 0) begin
      e.data = mk(tag, exp_ch);
      e.ch   = SELW'(exp_ch);
      e.last = exp_last;
      sb.push_back(e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got ch %0d data %h expected none", out_ch, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_ch", 64'(out_ch), 64'(e.ch));
`ifdef MUX_PKT_LOCK_EN
        chk("out_last", 64'(out_last), 64'(e.last));
`endif
      end
    end
  end

  logic [NCH-1:0] vv [15];
  int             ee [15];

  initial begin
    vv = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
           4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0100, 4'b0001, 4'b0001};
    ee = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3, 2, 0, 0};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'b1111, 1'b1, 32'h0, -1, 4'b0, 1'b0);
    tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_ch", 64'(out_ch), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'b0000, 1'b1, 32'(i), -1, 4'b0, 1'b0);
      @(negedge clk);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      tick();
    end

    drive(1'b0, 2'd2, 4'b1111, 1'b1, 32'hDEADBEEF, 2, 4'b0, 1'b0);
    @(negedge clk);
    chk("fixed_in_ready", 64'(in_ready), 64'b0100);
    tick();
    drive(1'b0, 2'd2, 4'b0000, 1'b1, 32'h0, -1, 4'b0, 1'b0);
    @(negedge clk);
    chk("fixed_out_valid", 64'(out_valid), 64'd1);
    chk("fixed_out_data", out_data, 64'hDEADBEEF_00000002);
    tick();
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_out_ch_hold", 64'(out_ch), 64'd2);
    tick();

    // Fairness over 1111 and 1010, then wrap/skip from ptr=3.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 2'd0, vv[i], 1'b1, 32'h100 + 32'(i), ee[i], 4'b0, 1'b0);
      @(negedge clk);
      chk("rr_in_ready", 64'(in_ready), 64'(1) << ee[i]);
      tick();
    end

    drive(1'b1, 2'd0, 4'b0010, 1'b1, 32'h200, 1, 4'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'b1000, 1'b0, 32'h300 + 32'(i), -1, 4'b0, 1'b0);
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_ch", 64'(out_ch), 64'd1);
      chk("bp_out_data", out_data, mk(32'h200, 1));
      tick();
    end
    drive(1'b1, 2'd0, 4'b1000, 1'b1, 32'h400, 3, 4'b0, 1'b0);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'b1000);
    tick();
    drive(1'b1, 2'd0, 4'b0000, 1'b1, 32'h0, -1, 4'b0, 1'b0);
    @(negedge clk);
    chk("no_bubble_out_valid", 64'(out_valid), 64'd1);
    chk("no_bubble_out_ch", 64'(out_ch), 64'd3);
    tick();
    tick();

`ifdef MUX_PKT_LOCK_EN
    drive(1'b1, 2'd0, 4'b0001, 1'b1, 32'h500, 0, 4'b0001, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'b0111, 1'b1, 32'h600 + 32'(i), 1,
            (i == 2) ? 4'b0010 : 4'b0000, (i == 2));
      @(negedge clk);
      chk("lock_in_ready", 64'(in_ready), 64'b0010);
      tick();
    end
    drive(1'b1, 2'd0, 4'b0111, 1'b1, 32'h700, 2, 4'b0100, 1'b1);
    @(negedge clk);
    chk("unlock_in_ready", 64'(in_ready), 64'b0100);
    tick();
    drive(1'b1, 2'd0, 4'b0000, 1'b1, 32'h0, -1, 4'b0, 1'b0);
    tick();
`endif

    // Reset while a word is held under backpressure; ptr was moved off 0 first.
    drive(1'b1, 2'd0, 4'b0010, 1'b1, 32'h800, -1, 4'b0, 1'b0);
    tick();
    drive(1'b1, 2'd0, 4'b0010, 1'b0, 32'h800, -1, 4'b0, 1'b0);
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_ch", 64'(out_ch), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 4'b0000, 1'b1, 32'h0, -1, 4'b0, 1'b0);
      @(negedge clk);
      chk("post_reset_idle", 64'(out_valid), 64'd0);
      tick();
    end
    drive(1'b1, 2'd0, 4'b1111, 1'b1, 32'h900, 0, 4'b0, 1'b0);
    @(negedge clk);
    chk("post_reset_ptr", 64'(in_ready), 64'b0001);
    tick();
    drive(1'b1, 2'd0, 4'b0000, 1'b1, 32'h0, -1, 4'b0, 1'b0);
    tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending words expected 0", sb.size());
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
